mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Parametrised N-master arbiter that multiplexes several bus masters onto the single memory router CPU-side port.
- Masters include the CPU, OAM/HDMA DMA engines and the debug port. Successor to the single-master hookup, where the CPU drives the router directly.
- Supports fixed-priority or round-robin arbitration, locked bursts, per-master registered read return and write/read conflict detection.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (1..8); master 0 is highest priority in fixed mode.
- ADDR_WIDTH, 16, address width.
- DATA_WIDTH, 8, data width.
- ROUND_ROBIN, 0, 0 = fixed priority, 1 = round-robin starting after the last owner.
- MAX_HOLD, 160, maximum consecutive locked cycles; used only with the optional feature.

Ports:
- I_CLK  in  1  system clock.
- I_RESET  in  1  synchronous reset, active-high.
- I_REQ  in  NUM_MASTERS  per-master bus request.
- I_LOCK  in  NUM_MASTERS  per-master burst lock; meaningful only while that master is granted.
- I_ADDR  in  NUM_MASTERS*ADDR_WIDTH  flattened master addresses; master k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- I_WDATA  in  NUM_MASTERS*DATA_WIDTH  flattened write data, same packing.
- I_WE_L  in  NUM_MASTERS  per-master write strobe, active-low.
- I_RE_L  in  NUM_MASTERS  per-master read strobe, active-low.
- O_GNT  out  NUM_MASTERS  one-hot registered grant.
- O_RDATA  out  DATA_WIDTH  registered read data, shared by all masters.
- O_RVALID  out  NUM_MASTERS  one-cycle pulse marking O_RDATA as valid for master k.
- O_CONFLICT  out  1  one-cycle pulse: granted master drove WE_L and RE_L low together.
- O_BUS_ADDR  out  ADDR_WIDTH  address to the router.
- IO_BUS_DATA  inout  DATA_WIDTH  tri-state data to the router.
- O_BUS_WE_L  out  1  write strobe to the router, active-low.
- O_BUS_RE_L  out  1  read strobe to the router, active-low.

Behaviour:
- Clock and reset: one clock, I_CLK. Reset is synchronous, active-high, on I_RESET.
- Reset values:
  - O_GNT = 0, O_RDATA = 0, O_RVALID = 0, O_CONFLICT = 0.
  - Round-robin pointer = NUM_MASTERS-1, so master 0 wins first.
  - Hold counter = 0. State = IDLE.
- States:
  - IDLE: no grant.
  - OWNED: exactly one O_GNT bit set.
- Arbitration decision, evaluated every cycle:
  - Candidate set = I_REQ.
  - If the current owner has I_LOCK=1 and I_REQ=1, the owner is kept.
  - Otherwise the winner is chosen by mode:
    - fixed: lowest index.
    - round-robin: first requester after the last owner, wrapping from NUM_MASTERS-1 to 0.
  - The winner is registered into O_GNT on the next edge (1-cycle grant latency).
  - No requesters → IDLE next cycle.
- Owner switching:
  - An unlocked owner that keeps requesting can be pre-empted next cycle by a higher-priority (fixed) or next-in-turn (round-robin) requester.
  - A sole requester holds the grant indefinitely.
- Downstream bus, combinational from the registered owner:
  - O_BUS_ADDR = owner address.
  - O_BUS_WE_L / O_BUS_RE_L = owner strobes.
  - IO_BUS_DATA = owner I_WDATA only when O_BUS_WE_L=0; Z otherwise.
  - IDLE: address 0, both strobes 1, data Z.
- Conflict: owner WE_L=0 and RE_L=0 in the same cycle →
  - both bus strobes forced to 1 that cycle;
  - O_CONFLICT pulses the next cycle;
  - no O_RVALID.
- Read return: on an edge where O_BUS_RE_L=0, IO_BUS_DATA is sampled into O_RDATA and O_RVALID[owner] pulses for 1 cycle. Read latency = 1 cycle from the granted RE_L. O_RDATA holds its value until the next read.
- Strobes from non-granted masters are ignored; they have no effect and produce no error.
- Reset mid-operation: all state returns to reset values on the next edge. Bus strobes go to 1 in the same cycle that I_RESET is sampled, because the owner is cleared.
- Ungranted master behaviour: a master dropping I_REQ while not granted has no effect.

Optional Feature:
- Macro: GB_ARB_HOLD_LIMIT_EN.
- With the macro:
  - The hold counter increments each cycle the owner keeps the grant with I_LOCK=1.
  - It resets to 0 on any owner change or when I_LOCK=0.
  - When it reaches MAX_HOLD, the owner's lock is ignored for one arbitration decision, so other requesters compete normally and the counter clears.
- Without the macro: no counter exists; a lock is honoured indefinitely.

Test Plan:
- Reset, no requests → O_GNT=00, O_BUS_WE_L=O_BUS_RE_L=1, IO_BUS_DATA=Z, O_BUS_ADDR=0000.
- Fixed mode, I_REQ=11 in the same cycle → O_GNT=01 next cycle. Master 0 drops REQ → O_GNT=10 the cycle after.
- Master 1 reads 0xC000 with the router returning 0x5A → O_RDATA=0x5A and O_RVALID=10 exactly one cycle after the bus RE_L.
- ROUND_ROBIN=1, NUM_MASTERS=3, all requesting continuously, no lock → grants rotate 001, 010, 100, 001.
- Master 1 granted with I_LOCK=1, master 0 requests → O_GNT stays 10. With GB_ARB_HOLD_LIMIT_EN and MAX_HOLD=4, O_GNT becomes 01 after 4 locked cycles.
- Granted master drives WE_L=RE_L=0 → bus strobes stay 1, O_CONFLICT pulses once, no O_RVALID. Assert I_RESET during an active grant → O_GNT=0 next edge.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// N-master arbiter in front of the memory router CPU-side port: fixed or round-robin priority,
// locked bursts, registered read return, conflict detection. Optional hold limit: GB_ARB_HOLD_LIMIT_EN.
module mem_bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int ROUND_ROBIN = 0,
    parameter int MAX_HOLD    = 160
) (
    input  logic                              I_CLK,
    input  logic                              I_RESET,
    input  logic [NUM_MASTERS-1:0]            I_REQ,
    input  logic [NUM_MASTERS-1:0]            I_LOCK,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] I_ADDR,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] I_WDATA,
    input  logic [NUM_MASTERS-1:0]            I_WE_L,
    input  logic [NUM_MASTERS-1:0]            I_RE_L,
    output logic [NUM_MASTERS-1:0]            O_GNT,
    output logic [DATA_WIDTH-1:0]             O_RDATA,
    output logic [NUM_MASTERS-1:0]            O_RVALID,
    output logic                              O_CONFLICT,
    output logic [ADDR_WIDTH-1:0]             O_BUS_ADDR,
    inout  wire  [DATA_WIDTH-1:0]             IO_BUS_DATA,
    output logic                              O_BUS_WE_L,
    output logic                              O_BUS_RE_L
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    if (NUM_MASTERS < 1 || NUM_MASTERS > 8 || MAX_HOLD < 1) begin : g_bad_param
        $error("mem_bus_arbiter: NUM_MASTERS must be 1..8 and MAX_HOLD >= 1");
    end

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    state_t          state;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   win_idx;
    logic            win_any;
    logic            keep;
    logic            hold_ok;
    logic            active;
    logic            conflict_now;
    logic [ADDR_WIDTH-1:0] own_addr;
    logic [DATA_WIDTH-1:0] own_wdata;
    logic            own_we_l;
    logic            own_re_l;

`ifdef GB_ARB_HOLD_LIMIT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0] hold_cnt;
    assign hold_ok = (hold_cnt != HW'(MAX_HOLD));
`else
    assign hold_ok = 1'b1;
`endif

    // Owner is cleared combinationally while reset is asserted so the bus idles immediately.
    assign active = (state == OWNED) && !I_RESET;

    always_comb begin
        own_addr  = I_ADDR[int'(owner)*ADDR_WIDTH +: ADDR_WIDTH];
        own_wdata = I_WDATA[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
        own_we_l  = I_WE_L[owner];
        own_re_l  = I_RE_L[owner];
    end

    always_comb begin
        O_BUS_ADDR   = '0;
        O_BUS_WE_L   = 1'b1;
        O_BUS_RE_L   = 1'b1;
        conflict_now = 1'b0;
        if (active) begin
            O_BUS_ADDR   = own_addr;
            conflict_now = !own_we_l && !own_re_l;
            if (!conflict_now) begin
                O_BUS_WE_L = own_we_l;
                O_BUS_RE_L = own_re_l;
            end
        end
    end

    assign IO_BUS_DATA = (!O_BUS_WE_L) ? own_wdata : 'z;

    always_comb begin
        int unsigned c;
        logic found;
        win_any = |I_REQ;
        win_idx = '0;
        found   = 1'b0;
        c       = 0;
        keep    = (state == OWNED) && I_REQ[owner] && I_LOCK[owner] && hold_ok;
        if (keep) begin
            win_idx = owner;
        end else if (ROUND_ROBIN == 0) begin
            for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
                if (!found && I_REQ[i]) begin
                    win_idx = IW'(i);
                    found   = 1'b1;
                end
            end
        end else begin
            // Scan starts just after the last owner; the last owner itself is checked last.
            for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
                c = k + ptr;
                if (c >= NUM_MASTERS) c = c - NUM_MASTERS;
                if (!found && I_REQ[c]) begin
                    win_idx = IW'(c);
                    found   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state      <= IDLE;
            owner      <= '0;
            ptr        <= IW'(NUM_MASTERS - 1);
            O_GNT      <= '0;
            O_RDATA    <= '0;
            O_RVALID   <= '0;
            O_CONFLICT <= 1'b0;
`ifdef GB_ARB_HOLD_LIMIT_EN
            hold_cnt   <= '0;
`endif
        end else begin
            O_RVALID   <= '0;
            O_CONFLICT <= conflict_now;
            if (!O_BUS_RE_L) begin
                O_RDATA         <= IO_BUS_DATA;
                O_RVALID[owner] <= 1'b1;
            end
            if (win_any) begin
                state          <= OWNED;
                owner          <= win_idx;
                ptr            <= win_idx;
                O_GNT          <= '0;
                O_GNT[win_idx] <= 1'b1;
            end else begin
                state <= IDLE;
                O_GNT <= '0;
            end
`ifdef GB_ARB_HOLD_LIMIT_EN
            hold_cnt <= keep ? hold_cnt + 1'b1 : '0;
`endif
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a fixed-priority 2-master instance and a round-robin 3-master
// instance, checked every cycle against a spec-level model plus literal expectations.
module tb_mem_bus_arbiter;
    localparam int HOLD = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  req [2];
    logic [2:0]  lock [2];
    logic [2:0]  we_l [2];
    logic [2:0]  re_l [2];
    logic [15:0] addr [2][3];
    logic [7:0]  wdata [2][3];

    logic [1:0]  gnt0, rvalid0;
    logic [2:0]  gnt1, rvalid1;
    logic [7:0]  rdata0, rdata1;
    logic        conf0, conf1;
    logic [15:0] baddr0, baddr1;
    logic        bwe0, bre0, bwe1, bre1;
    wire  [7:0]  bdata0, bdata1;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    function automatic logic [7:0] router_data(input logic [15:0] a);
        return (a == 16'hC000) ? 8'h5A : (a[7:0] ^ a[15:8] ^ 8'h33);
    endfunction

    // Router side: drives read data while the arbiter's read strobe is low.
    assign bdata0 = (!bre0) ? router_data(baddr0) : 'z;
    assign bdata1 = (!bre1) ? router_data(baddr1) : 'z;

    mem_bus_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(16), .DATA_WIDTH(8),
                      .ROUND_ROBIN(0), .MAX_HOLD(HOLD)) u_fixed (
        .I_CLK(clk), .I_RESET(rst), .I_REQ(req[0][1:0]), .I_LOCK(lock[0][1:0]),
        .I_ADDR({addr[0][1], addr[0][0]}), .I_WDATA({wdata[0][1], wdata[0][0]}),
        .I_WE_L(we_l[0][1:0]), .I_RE_L(re_l[0][1:0]),
        .O_GNT(gnt0), .O_RDATA(rdata0), .O_RVALID(rvalid0), .O_CONFLICT(conf0),
        .O_BUS_ADDR(baddr0), .IO_BUS_DATA(bdata0), .O_BUS_WE_L(bwe0), .O_BUS_RE_L(bre0)
    );

    mem_bus_arbiter #(.NUM_MASTERS(3), .ADDR_WIDTH(16), .DATA_WIDTH(8),
                      .ROUND_ROBIN(1), .MAX_HOLD(HOLD)) u_rr (
        .I_CLK(clk), .I_RESET(rst), .I_REQ(req[1]), .I_LOCK(lock[1]),
        .I_ADDR({addr[1][2], addr[1][1], addr[1][0]}),
        .I_WDATA({wdata[1][2], wdata[1][1], wdata[1][0]}),
        .I_WE_L(we_l[1]), .I_RE_L(re_l[1]),
        .O_GNT(gnt1), .O_RDATA(rdata1), .O_RVALID(rvalid1), .O_CONFLICT(conf1),
        .O_BUS_ADDR(baddr1), .IO_BUS_DATA(bdata1), .O_BUS_WE_L(bwe1), .O_BUS_RE_L(bre1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: owner index (-1 = nobody), last owner, hold count, registered outputs.
    int          m_owner [2];
    int          m_last [2];
    int          m_hold [2];
    logic [7:0]  m_rdata [2];
    logic [2:0]  m_rvalid [2];
    logic        m_conf [2];

    always @(posedge clk) begin
        int n, o, w, c;
        bit conflict, locked;
        for (int d = 0; d < 2; d++) begin
            n = (d == 0) ? 2 : 3;
            if (rst) begin
                m_owner[d]  = -1;
                m_last[d]   = n - 1;
                m_hold[d]   = 0;
                m_rdata[d]  = '0;
                m_rvalid[d] = '0;
                m_conf[d]   = 1'b0;
            end else begin
                o = m_owner[d];
                m_rvalid[d] = '0;
                m_conf[d]   = 1'b0;
                if (o >= 0) begin
                    conflict  = !we_l[d][o] && !re_l[d][o];
                    m_conf[d] = conflict;
                    if (!re_l[d][o] && !conflict) begin
                        m_rdata[d]     = router_data(addr[d][o]);
                        m_rvalid[d][o] = 1'b1;
                    end
                end
                locked = (o >= 0) && req[d][o] && lock[d][o];
`ifdef GB_ARB_HOLD_LIMIT_EN
                if (locked && m_hold[d] == HOLD) locked = 1'b0;
`endif
                w = -1;
                if (locked) w = o;
                else begin
                    for (int k = 1; k <= n; k++) begin
                        c = (d == 0) ? k - 1 : (m_last[d] + k) % n;
                        if (w < 0 && req[d][c]) w = c;
                    end
                end
                m_hold[d]  = locked ? m_hold[d] + 1 : 0;
                m_owner[d] = w;
                if (w >= 0) m_last[d] = w;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        int o;
        bit cf;
        logic [2:0]  a_gnt, a_rv, e_gnt;
        logic [7:0]  a_rd, a_bd;
        logic [15:0] a_ad, e_ad;
        logic        a_cf, a_we, a_re, e_we, e_re;
        if (cyc > 0) begin
            for (int d = 0; d < 2; d++) begin
                o     = m_owner[d];
                e_gnt = (o >= 0) ? 3'(1 << o) : 3'b000;
                a_gnt = (d == 0) ? {1'b0, gnt0} : gnt1;
                a_rv  = (d == 0) ? {1'b0, rvalid0} : rvalid1;
                a_rd  = (d == 0) ? rdata0 : rdata1;
                a_cf  = (d == 0) ? conf0 : conf1;
                a_ad  = (d == 0) ? baddr0 : baddr1;
                a_we  = (d == 0) ? bwe0 : bwe1;
                a_re  = (d == 0) ? bre0 : bre1;
                a_bd  = (d == 0) ? bdata0 : bdata1;
                e_ad = '0; e_we = 1'b1; e_re = 1'b1;
                if (o >= 0 && !rst) begin
                    e_ad = addr[d][o];
                    cf   = !we_l[d][o] && !re_l[d][o];
                    if (!cf) begin
                        e_we = we_l[d][o];
                        e_re = re_l[d][o];
                    end
                end
                chk($sformatf("gnt[%0d]", d), 32'(a_gnt), 32'(e_gnt));
                chk($sformatf("rvalid[%0d]", d), 32'(a_rv), 32'(m_rvalid[d]));
                chk($sformatf("rdata[%0d]", d), 32'(a_rd), 32'(m_rdata[d]));
                chk($sformatf("conflict[%0d]", d), 32'(a_cf), 32'(m_conf[d]));
                chk($sformatf("bus_addr[%0d]", d), 32'(a_ad), 32'(e_ad));
                chk($sformatf("bus_we_l[%0d]", d), 32'(a_we), 32'(e_we));
                chk($sformatf("bus_re_l[%0d]", d), 32'(a_re), 32'(e_re));
                if (!e_we) chk($sformatf("bus_wdata[%0d]", d), 32'(a_bd), 32'(wdata[d][o]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req[d] = '0; lock[d] = '0; we_l[d] = '1; re_l[d] = '1;
            for (int k = 0; k < 3; k++) begin
                addr[d][k]  = 16'(16'h1000 * (k + 1) + d * 16'h0100);
                wdata[d][k] = 8'(8'h10 * (k + 1) + d);
            end
        end
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("lit_reset_gnt", 32'(gnt0), 32'h0);
        chk("lit_reset_we", 32'(bwe0), 32'h1);
        chk("lit_reset_re", 32'(bre0), 32'h1);
        chk("lit_reset_addr", 32'(baddr0), 32'h0);

        req[0] = 3'b011; tick();
        chk("lit_fixed_both", 32'(gnt0), 32'h1);
        req[0] = 3'b010; tick();
        chk("lit_fixed_m1", 32'(gnt0), 32'h2);

        addr[0][1] = 16'hC000; re_l[0] = 3'b101; tick();
        chk("lit_read_data", 32'(rdata0), 32'h5A);
        chk("lit_read_valid", 32'(rvalid0), 32'h2);
        re_l[0] = 3'b111; tick();
        chk("lit_read_pulse", 32'(rvalid0), 32'h0);
        chk("lit_read_hold", 32'(rdata0), 32'h5A);

        req[1] = 3'b111;
        tick(); chk("lit_rr_1", 32'(gnt1), 32'h1);
        tick(); chk("lit_rr_2", 32'(gnt1), 32'h2);
        tick(); chk("lit_rr_3", 32'(gnt1), 32'h4);
        tick(); chk("lit_rr_4", 32'(gnt1), 32'h1);
        req[1] = 3'b000; tick();

        req[0] = 3'b011; lock[0] = 3'b010; tick();
        chk("lit_lock_keep", 32'(gnt0), 32'h2);
`ifdef GB_ARB_HOLD_LIMIT_EN
        tick(); tick(); tick();
        chk("lit_lock_held", 32'(gnt0), 32'h2);
        tick();
        chk("lit_lock_limit", 32'(gnt0), 32'h1);
`else
        repeat (5) tick();
        chk("lit_lock_long", 32'(gnt0), 32'h2);
`endif
        lock[0] = 3'b000; req[0] = 3'b001; tick();
        chk("lit_unlock", 32'(gnt0), 32'h1);

        wdata[0][0] = 8'hA5; we_l[0] = 3'b110; tick();
        we_l[0] = 3'b111;

        we_l[0] = 3'b110; re_l[0] = 3'b110; #1;
        chk("lit_conf_we", 32'(bwe0), 32'h1);
        chk("lit_conf_re", 32'(bre0), 32'h1);
        tick();
        chk("lit_conf_pulse", 32'(conf0), 32'h1);
        chk("lit_conf_norv", 32'(rvalid0), 32'h0);
        we_l[0] = 3'b111; re_l[0] = 3'b111; tick();
        chk("lit_conf_clear", 32'(conf0), 32'h0);

        re_l[0] = 3'b110; rst = 1'b1; #1;
        chk("lit_rst_re", 32'(bre0), 32'h1);
        tick();
        chk("lit_rst_gnt", 32'(gnt0), 32'h0);
        rst = 1'b0; re_l[0] = 3'b111; tick();

        for (int i = 0; i < 40; i++) begin
            req[0]  = 3'(i % 4);
            req[1]  = 3'((i * 5 + 3) % 8);
            for (int d = 0; d < 2; d++) begin
                lock[d] = ((i / 6) % 2 == 1) ? 3'b111 : 3'b000;
                re_l[d] = (i % 3 == 0) ? 3'b000 : 3'b111;
                we_l[d] = (i % 7 == 0) ? 3'b000 : ((i % 5 == 1) ? 3'b000 : 3'b111);
                if (i % 5 == 1) re_l[d] = 3'b111;
                for (int k = 0; k < 3; k++) begin
                    addr[d][k]  = 16'(i * 257 + k * 4099 + d);
                    wdata[d][k] = 8'(i * 13 + k);
                end
            end
            tick();
        end
        req[0] = '0; req[1] = '0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
